fwr_fifo: RTL and testbench
===========================

# fwr_fifo

Synchronous first-word-fall-through FIFO that sits directly downstream of the AXIS-to-FIFO width packer on the S_AXIS_ACLK domain. It absorbs the packer's single-cycle `fwr_vld` write pulses (AXI4_DATA_WIDTH wide), returns `fwr_full`/`fwr_cnt` to it, and presents the data through a valid/ready read port. The AXI4 burst write master consumes that read port, using `frd_burst_rdy` to launch bursts.

## Interface
- `FAW`, 8: log2 of FIFO capacity; capacity is 2^FAW entries.
- `DATA_WIDTH`, 128: entry width; equals the packer's AXI4_DATA_WIDTH.
- `BURST_LEN`, 16: entry threshold for `frd_burst_rdy`; legal range 1..2^FAW.
- `S_AXIS_ACLK` in 1: clock; all logic is on this rising edge.
- `S_AXIS_ARESETN` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous clear of FIFO contents.
- `fwr_vld` in 1: write strobe; not gated by `fwr_rdy` upstream.
- `fwr_dat` in DATA_WIDTH: write data.
- `fwr_rdy` out 1: combinational `!fwr_full`.
- `fwr_full` out 1: registered; high when count == 2^FAW.
- `fwr_cnt` out FAW+1: registered occupancy, 0..2^FAW.
- `frd_vld` out 1: head entry valid.
- `frd_rdy` in 1: consumer accepts the head.
- `frd_dat` out DATA_WIDTH: head entry.
- `frd_burst_rdy` out 1: registered; high when count >= BURST_LEN.
- `ovf_sticky` out 1, `ovf_cnt` out 16, `ovf_clr` in 1: present only with FWR_FIFO_OVF_EN.

## Operation
- Write accepted iff `fwr_vld` and the registered count < 2^FAW in that cycle. A same-cycle read does not make room, so a write at full is dropped.
- Read occurs iff `frd_vld & frd_rdy`. `frd_dat` is stable while `frd_vld & !frd_rdy`.
- Count update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on both or neither.
  - Never wraps.
- Pointers: FAW bits, wrap modulo 2^FAW. Data order is strictly preserved.
- Write and read in the same cycle at count 1: the head is consumed. The new entry becomes the head the next cycle with no bubble, `frd_vld` stays 1.
- Empty: `frd_vld`=0 and `frd_dat` holds its last value. `frd_rdy` is ignored.
- `flush`:
  - Next cycle: count=0, pointers=0, `frd_vld`=0, `frd_burst_rdy`=0.
  - A write or read in the flush cycle is discarded.
  - Overflow stats are not cleared.
- Reset values:
  - `fwr_cnt`=0, `fwr_full`=0, `fwr_rdy`=1, `frd_vld`=0.
  - `frd_dat`=0, `frd_burst_rdy`=0, `ovf_sticky`=0, `ovf_cnt`=0.
  - Memory contents are not reset.
- Reset asserted mid-operation returns all outputs to reset values immediately. Contents are lost.

## Timing
- Write→read latency: a write at edge N into an empty FIFO gives `frd_vld`=1 after edge N+1.
- `fwr_cnt`, `fwr_full` and `frd_burst_rdy` reflect all accepted operations up to and including the previous edge.
- Back-to-back writes and reads every cycle sustain 1 entry/cycle in both directions.
- `frd_dat` is driven from a register or the memory output. There is no combinational path from `fwr_dat` to `frd_dat`.

## Configuration
- `FWR_FIFO_OVF_EN` defined: compiles in the overflow ports and logic.
  - Each dropped write (`fwr_vld` at full, not flushing) sets `ovf_sticky` and increments `ovf_cnt`.
  - `ovf_cnt` saturates at 0xFFFF.
  - `ovf_clr` clears both next cycle; `ovf_clr` has priority over a simultaneous drop.
- Undefined: the ports are absent and dropped writes are silent.

## Structure
- Shared package `fwr_pkg`:
  - DATA_WIDTH/FAW defaults.
  - Overflow counter width constant (16).
  - Count typedef width FAW+1.
- Sub-module `fwr_fifo_ram`: simple dual-port RAM, 2^FAW × DATA_WIDTH, one write port, one synchronous read port, no reset. The top holds pointers, count, FWFT prefetch/head register, flags and overflow logic.

## Test plan
- Single write 0xA…A at empty → `frd_vld`=1 one cycle later, `frd_dat`=0xA…A, `fwr_cnt`=1. Read → `fwr_cnt`=0, `frd_vld`=0.
- FAW=4, 16 writes with `frd_rdy`=0 → `fwr_full`=1, `fwr_rdy`=0, `fwr_cnt`=16. A 17th write is dropped and `ovf_cnt`=1 (macro on). Drain yields 16 in-order values.
- Continuous write+read, 1000 incrementing words → output matches input, `fwr_cnt` constant, no `frd_vld` bubble after the first word.
- BURST_LEN=16: 15 writes → `frd_burst_rdy`=0. 16th → 1 the cycle after. One read → 0.
- At full, simultaneous `fwr_vld` and a read → write dropped, `fwr_cnt`=15 the next cycle.
- Mid-stream `flush` with 7 entries → next cycle `fwr_cnt`=0, `frd_vld`=0. A subsequent write appears as the head. Async reset mid-burst → all outputs at reset values.

Source files
------------

// File: rtl/fwr_pkg.sv
// Shared types and defaults for the packer-side FWFT FIFO.
// Imported by fwr_fifo; holds sizing defaults and head-source encoding.
package fwr_pkg;

  localparam int FWR_FAW   = 8;
  localparam int FWR_DW    = 128;
  localparam int FWR_OVF_W = 16;

  typedef logic [FWR_FAW:0] fwr_cnt_t;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_RAM,
    SRC_BYP
  } fwr_src_e;

endpackage

// File: rtl/fwr_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// No reset; contents and read register power up undefined.
module fwr_fifo_ram #(
  parameter int AW = 8,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fwr_fifo.sv
// First-word-fall-through FIFO behind the AXIS width packer.
// Define FWR_FIFO_OVF_EN to add dropped-write stats (ovf_*).
module fwr_fifo
  import fwr_pkg::*;
#(
  parameter int FAW        = FWR_FAW,
  parameter int DATA_WIDTH = FWR_DW,
  parameter int BURST_LEN  = 16
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESETN,
  input  logic                  flush,
  input  logic                  fwr_vld,
  input  logic [DATA_WIDTH-1:0] fwr_dat,
  output logic                  fwr_rdy,
  output logic                  fwr_full,
  output logic [FAW:0]          fwr_cnt,
  output logic                  frd_vld,
  input  logic                  frd_rdy,
  output logic [DATA_WIDTH-1:0] frd_dat,
`ifdef FWR_FIFO_OVF_EN
  input  logic                  ovf_clr,
  output logic                  ovf_sticky,
  output logic [FWR_OVF_W-1:0]  ovf_cnt,
`endif
  output logic                  frd_burst_rdy
);

  localparam logic [FAW:0]   CAP   = (FAW+1)'(2**FAW);
  localparam logic [FAW:0]   BL    = (FAW+1)'(BURST_LEN);
  localparam logic [FAW:0]   ONE_C = (FAW+1)'(1);
  localparam logic [FAW-1:0] ONE_P = FAW'(1);

  logic [FAW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [FAW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [FAW:0]          cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic                  burst_q, burst_d;
  logic                  vld_q, vld_d;
  fwr_src_e              src_q, src_d;
  logic [DATA_WIDTH-1:0] byp_q, byp_d;
  logic                  we, rd, re;
  logic [DATA_WIDTH-1:0] ram_dat;

  always_comb begin
    we       = fwr_vld & ~full_q & ~flush;
    rd       = vld_q & frd_rdy & ~flush;
    re       = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    src_d    = src_q;
    byp_d    = byp_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      vld_d    = 1'b0;
    end else begin
      if (we) wr_ptr_d = wr_ptr_q + ONE_P;
      if (rd) rd_ptr_d = rd_ptr_q + ONE_P;
      if (we && !rd) cnt_d = cnt_q + ONE_C;
      if (rd && !we) cnt_d = cnt_q - ONE_C;
      // Head is fetched from RAM only once committed; a write
      // landing as the sole successor is forwarded via byp_q.
      if (!vld_q) begin
        if (cnt_q != '0) begin
          re    = 1'b1;
          vld_d = 1'b1;
          src_d = SRC_RAM;
        end
      end else if (rd) begin
        if (cnt_q > ONE_C) begin
          re    = 1'b1;
          src_d = SRC_RAM;
        end else if (we) begin
          byp_d = fwr_dat;
          src_d = SRC_BYP;
        end else begin
          vld_d = 1'b0;
        end
      end
    end
    full_d  = (cnt_d == CAP);
    burst_d = (cnt_d >= BL);
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      burst_q  <= 1'b0;
      vld_q    <= 1'b0;
      src_q    <= SRC_ZERO;
      byp_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      burst_q  <= burst_d;
      vld_q    <= vld_d;
      src_q    <= src_d;
      byp_q    <= byp_d;
    end
  end

  fwr_fifo_ram #(
    .AW(FAW),
    .DW(DATA_WIDTH)
  ) u_ram (
    .clk  (S_AXIS_ACLK),
    .we   (we),
    .waddr(wr_ptr_q),
    .wdata(fwr_dat),
    .re   (re),
    .raddr(rd_ptr_d),
    .rdata(ram_dat)
  );

  always_comb begin
    frd_dat = '0;
    unique case (src_q)
      SRC_RAM: frd_dat = ram_dat;
      SRC_BYP: frd_dat = byp_q;
      default: frd_dat = '0;
    endcase
  end

  assign fwr_rdy       = ~full_q;
  assign fwr_full      = full_q;
  assign fwr_cnt       = cnt_q;
  assign frd_vld       = vld_q;
  assign frd_burst_rdy = burst_q;

`ifdef FWR_FIFO_OVF_EN
  logic                 ovf_sticky_q, ovf_sticky_d;
  logic [FWR_OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic                 drop;

  always_comb begin
    drop         = fwr_vld & full_q & ~flush;
    ovf_sticky_d = ovf_sticky_q;
    ovf_cnt_d    = ovf_cnt_q;
    if (ovf_clr) begin
      ovf_sticky_d = 1'b0;
      ovf_cnt_d    = '0;
    end else if (drop) begin
      ovf_sticky_d = 1'b1;
      if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + FWR_OVF_W'(1);
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      ovf_sticky_q <= 1'b0;
      ovf_cnt_q    <= '0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
  assign ovf_cnt    = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_fwr_fifo.sv
// Self-checking bench for fwr_fifo against a queue-based model.
// Exercises ovf_* when built with FWR_FIFO_OVF_EN.
module tb_fwr_fifo;

  localparam int FAW = 4;
  localparam int DW  = 32;
  localparam int BL  = 16;
  localparam int CAP = 16;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          flush   = 1'b0;
  logic          fwr_vld = 1'b0;
  logic [DW-1:0] fwr_dat = '0;
  logic          frd_rdy = 1'b0;
  logic          fwr_rdy, fwr_full, frd_vld, frd_burst_rdy;
  logic [FAW:0]  fwr_cnt;
  logic [DW-1:0] frd_dat;
`ifdef FWR_FIFO_OVF_EN
  logic          ovf_clr = 1'b0;
  logic          ovf_sticky;
  logic [15:0]   ovf_cnt;
`endif

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] q[$];
  logic          m_vld    = 1'b0;
  logic [DW-1:0] m_dat    = '0;
  logic          m_sticky = 1'b0;
  int            m_ovf    = 0;

  always #5 clk = ~clk;

  fwr_fifo #(
    .FAW(FAW),
    .DATA_WIDTH(DW),
    .BURST_LEN(BL)
  ) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESETN(rst_n),
    .flush         (flush),
    .fwr_vld       (fwr_vld),
    .fwr_dat       (fwr_dat),
    .fwr_rdy       (fwr_rdy),
    .fwr_full      (fwr_full),
    .fwr_cnt       (fwr_cnt),
    .frd_vld       (frd_vld),
    .frd_rdy       (frd_rdy),
    .frd_dat       (frd_dat),
`ifdef FWR_FIFO_OVF_EN
    .ovf_clr       (ovf_clr),
    .ovf_sticky    (ovf_sticky),
    .ovf_cnt       (ovf_cnt),
`endif
    .frd_burst_rdy (frd_burst_rdy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cnt", DW'(fwr_cnt), DW'(q.size()));
    chk("full", DW'(fwr_full), DW'(q.size() == CAP));
    chk("rdy", DW'(fwr_rdy), DW'(q.size() != CAP));
    chk("burst", DW'(frd_burst_rdy), DW'(q.size() >= BL));
    chk("vld", DW'(frd_vld), DW'(m_vld));
    chk("dat", frd_dat, m_dat);
`ifdef FWR_FIFO_OVF_EN
    chk("ovf_sticky", DW'(ovf_sticky), DW'(m_sticky));
    chk("ovf_cnt", DW'(ovf_cnt), DW'(m_ovf));
`endif
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d,
                      input logic r, input logic f);
    int pre;
    bit wr, rd, drop;
    fwr_vld = v;
    fwr_dat = d;
    frd_rdy = r;
    flush   = f;
    @(posedge clk);
    pre  = q.size();
    drop = 1'b0;
    if (f) begin
      q.delete();
      m_vld = 1'b0;
    end else begin
      wr   = v && (pre < CAP);
      rd   = m_vld && r;
      drop = v && (pre == CAP);
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(d);
      // New data becomes visible one cycle after landing in an
      // empty FIFO, but immediately replaces a consumed head.
      if (!m_vld) m_vld = (pre > 0);
      else if (rd) m_vld = (q.size() > 0);
      if (m_vld) m_dat = q[0];
    end
`ifdef FWR_FIFO_OVF_EN
    if (ovf_clr) begin
      m_sticky = 1'b0;
      m_ovf    = 0;
    end else if (drop) begin
      m_sticky = 1'b1;
      if (m_ovf < 65535) m_ovf++;
    end
`endif
    #1;
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    m_vld    = 1'b0;
    m_dat    = '0;
    m_sticky = 1'b0;
    m_ovf    = 0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++)
      step(1'b1, 32'h100 + i, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_0001, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_0002, 1'b1, 1'b0);
`ifdef FWR_FIFO_OVF_EN
    ovf_clr = 1'b1;
    step(1'b1, 32'hDEAD_0003, 1'b0, 1'b0);
    ovf_clr = 1'b0;
`endif
    for (int i = 0; i < 17; i++)
      step(1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 1000; i++)
      step(1'b1, 32'h1000 + i, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 7) != 0, $urandom,
           $urandom_range(0, 5) == 0, 1'b0);

    for (int i = 0; i < 20; i++)
      step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++)
      step(1'b1, 32'h700 + i, 1'b0, 1'b0);
    step(1'b1, 32'h5555_5555, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0077, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++)
      step(1'b1, 32'h900 + i, i[0], 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    fwr_vld = 1'b0;
    frd_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
